// File: rtl/data_ram_resp.sv
// data_ram_resp: word-addressed data RAM behind a CPU data port.
// A request is captured on acceptance, held for WAIT_CYCLES wait states,
// performed in RESP, and answered with a one-cycle ready strobe that
// carries err for misaligned or out-of-range addresses.
module data_ram_resp #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        wea,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        accept;

  // Captured request; data only, so no reset.
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic        we_p0;

  logic [31:0] mem [DEPTH];

  logic          req_err;
  logic [AW-1:0] idx;
  logic          do_resp;
  logic          mem_we;

  // Misaligned byte address or word index beyond the array.
  function automatic logic addr_fault(input logic [31:0] a);
    logic [31:0] word;
    word = {2'b00, a[31:2]};
    return (a[1:0] != 2'b00) || (word >= 32'(DEPTH));
  endfunction

  assign req_err = addr_fault(addr_p0);
  assign idx     = addr_p0[AW+1:2];
  assign do_resp = (state == RESP);
  assign mem_we  = do_resp && we_p0 && !req_err;
  assign busy    = (state != IDLE);

  // Next-state logic: accept in IDLE, count down wait states, respond once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // ---- stage p0: request capture at the acceptance edge ----
  // Latch the request so inputs need not be held afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= addr;
      wdata_p0 <= wdata;
      we_p0    <= wea;
    end
  end

  // ---- stage p1: access performed on the RESP edge ----
  // Storage write; an asynchronous reset forces IDLE, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_p0;
    end
  end

  // State, counter and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= do_resp;
      err   <= do_resp && req_err;
      if (do_resp) begin
        if (req_err) begin
          rdata <= 32'h0000_0000;
        end else if (!we_p0) begin
          rdata <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: one instance with WAIT_CYCLES=2 and
// one with WAIT_CYCLES=0, sharing clock and reset.
module tb_data_ram_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        ena, wea;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;

  logic        ena0, wea0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0, busy0;

  int n_tests = 0;
  int n_fail  = 0;

  data_ram_resp #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  data_ram_resp #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ena(ena0), .wea(wea0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request to the selected instance and wait for its ready strobe.
  task automatic req(input bit sel0, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat,
                     output logic [31:0] rd, output logic e);
    int  lat;
    bit  found;
    lat = 0;
    found = 0;
    rd = 32'h0;
    e = 1'b0;
    @(negedge clk);
    if (sel0) begin ena0 = 1'b1; wea0 = we; addr0 = a; wdata0 = d; end
    else      begin ena  = 1'b1; wea  = we; addr  = a; wdata  = d; end
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance: they must not matter any more.
    if (sel0) begin ena0 = 1'b0; wea0 = ~we; addr0 = 32'h0000_0004; wdata0 = 32'hFFFF_FFFF; end
    else      begin ena  = 1'b0; wea  = ~we; addr  = 32'h0000_0004; wdata  = 32'hFFFF_FFFF; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((sel0 ? ready0 : ready) === 1'b1) begin
        found = 1;
        lat = k;
        rd = sel0 ? rdata0 : rdata;
        e  = sel0 ? err0 : err;
        check("busy_in_ready", 32'(sel0 ? busy0 : busy), 32'd0);
        break;
      end
      check("busy_waiting", 32'(sel0 ? busy0 : busy), 32'd1);
      check("err_without_ready", 32'(sel0 ? err0 : err), 32'd0);
    end
    if (!found) $display("FAIL ready_timeout: got no ready expected ready within 20 cycles");
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  logic [31:0] rd;
  logic        e;

  initial begin
    ena = 0; wea = 0; addr = 0; wdata = 0;
    ena0 = 0; wea0 = 0; addr0 = 0; wdata0 = 0;

    // Reset takes effect with no clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_rdata", rdata,      32'h0);
    check("rst_busy0", 32'(busy0), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Store then load at 0x10; first request right after reset release.
    req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4, rd, e);
    check("st10_err", 32'(e), 32'd0);
    check("st10_rdata_hold", rd, 32'h0);
    req(0, 1'b0, 32'h10, 32'h0, 4, rd, e);
    check("ld10_err", 32'(e), 32'd0);
    check("ld10_rdata", rd, 32'hDEADBEEF);

    // Misaligned store must not write.
    req(0, 1'b1, 32'h13, 32'h1234, 4, rd, e);
    check("mis_err", 32'(e), 32'd1);
    check("mis_rdata", rd, 32'h0);
    req(0, 1'b0, 32'h10, 32'h0, 4, rd, e);
    check("ld10_after_mis", rd, 32'hDEADBEEF);
    check("ld10_after_mis_err", 32'(e), 32'd0);

    // Out-of-range and last valid word.
    req(0, 1'b0, 32'h400, 32'h0, 4, rd, e);
    check("oor_err", 32'(e), 32'd1);
    check("oor_rdata", rd, 32'h0);
    req(0, 1'b1, 32'h3FC, 32'h3FC3FC00, 4, rd, e);
    check("st3fc_err", 32'(e), 32'd0);
    check("st3fc_rdata_hold", rd, 32'h0);
    req(0, 1'b0, 32'h3FC, 32'h0, 4, rd, e);
    check("ld3fc_err", 32'(e), 32'd0);
    check("ld3fc_rdata", rd, 32'h3FC3FC00);

    // Preload words 0..15 with C0DE0000+i.
    for (int i = 0; i < 16; i++) begin
      req(0, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), 4, rd, e);
      check("preload_err", 32'(e), 32'd0);
    end

    // Back-to-back: ena held high, addr advances one word per cycle.
    // Accepted at cycles 0,4,8 -> words 0,4,8; ready seen at cycles 4,8,12.
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        check("b2b_ready", 32'(ready), (k % 4 == 0) ? 32'd1 : 32'd0);
        check("b2b_busy",  32'(busy),  (k % 4 == 0) ? 32'd0 : 32'd1);
        if (k % 4 == 0) begin
          check("b2b_rdata", rdata, 32'hC0DE0000 + 32'(k - 4));
          check("b2b_err", 32'(err), 32'd0);
        end
      end
      if (k == 12) begin
        ena = 1'b0;
      end else begin
        ena = 1'b1; wea = 1'b0; addr = 32'(k * 4);
      end
    end

    // Reset during WAIT aborts the store.
    @(negedge clk);
    ena = 1'b1; wea = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555;
    @(posedge clk);
    #1 ena = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_err",   32'(err),   32'd0);
    check("abort_rdata", rdata,      32'h0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_ready", 32'(ready), 32'd0);
    end
    req(0, 1'b0, 32'h20, 32'h0, 4, rd, e);
    check("abort_ld20", rd, 32'hC0DE0008);
    check("abort_ld20_err", 32'(e), 32'd0);

    // Zero wait states.
    req(1, 1'b1, 32'h8, 32'h5A5A5A5A, 2, rd, e);
    check("wc0_st_err", 32'(e), 32'd0);
    req(1, 1'b0, 32'h8, 32'h0, 2, rd, e);
    check("wc0_ld_err", 32'(e), 32'd0);
    check("wc0_ld_rdata", rd, 32'h5A5A5A5A);
    req(1, 1'b0, 32'h101, 32'h0, 2, rd, e);
    check("wc0_mis_err", 32'(e), 32'd1);
    check("wc0_mis_rdata", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
